// File: rtl/sig_control_ped.sv
`default_nettype none
// ============================================================================
//  Module   : sig_control_ped
//  Purpose  : Highway / country-road signal controller with programmable
//             timing, latched pedestrian request with walk output, and a
//             night flash mode. Outputs are Moore-decoded from state.
//  Revision : 1.0  initial release
// ============================================================================
module sig_control_ped #(
  parameter int DLY_W = 4
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             x,
  input  logic             ped_req,
  input  logic             flash,
  input  logic [DLY_W-1:0] y2rdelay,
  input  logic [DLY_W-1:0] r2gdelay,
  input  logic [DLY_W-1:0] min_green,
  input  logic [DLY_W-1:0] max_green,
  output logic [1:0]       hwy,
  output logic [1:0]       cntry,
  output logic             ped_walk,
  output logic [2:0]       state
);

  // State encoding (visible on the debug state output)
  localparam logic [2:0] S_HG    = 3'd0;
  localparam logic [2:0] S_HY    = 3'd1;
  localparam logic [2:0] S_AR1   = 3'd2;
  localparam logic [2:0] S_CG    = 3'd3;
  localparam logic [2:0] S_CY    = 3'd4;
  localparam logic [2:0] S_AR2   = 3'd5;
  localparam logic [2:0] S_FLASH = 3'd6;

  // Lamp encoding
  localparam logic [1:0] L_RED = 2'd0;
  localparam logic [1:0] L_YEL = 2'd1;
  localparam logic [1:0] L_GRN = 2'd2;
  localparam logic [1:0] L_OFF = 2'd3;

  logic [2:0]       state_q,       state_d;
  logic [DLY_W-1:0] timer_q,       timer_d;
  logic             ped_pending_q, ped_pending_d;
  logic             ped_entered_q, ped_entered_d;
  logic             flash_phase_q, flash_phase_d;

  logic [DLY_W-1:0] timer_dec;
  logic             timer_zero;
  logic             enter_cg;

  // A delay of D cycles loads D-1; D=0 behaves like D=1.
  function automatic logic [DLY_W-1:0] load_val(input logic [DLY_W-1:0] d);
    if (d == '0) begin
      return '0;
    end
    return d - DLY_W'(1);
  endfunction

  // Saturating down-count of the state timer
  always_comb begin
    timer_zero = (timer_q == '0);
    timer_dec  = timer_zero ? '0 : (timer_q - DLY_W'(1));
  end

  // Next-state, timer load and per-phase flags
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_dec;
    ped_entered_d = ped_entered_q;
    flash_phase_d = 1'b0;

    case (state_q)
      S_HG: begin
        // Flash has priority and ignores the minimum-green hold.
        if (flash) begin
          state_d = S_FLASH;
          timer_d = '0;
        end else if (timer_zero && (x || ped_pending_q)) begin
          state_d = S_HY;
          timer_d = load_val(y2rdelay);
        end
      end

      S_HY: begin
        if (timer_zero) begin
          state_d = S_AR1;
          timer_d = load_val(r2gdelay);
        end
      end

      S_AR1: begin
        if (timer_zero) begin
          state_d       = S_CG;
          timer_d       = load_val(max_green);
          // Remember why the country phase started; a pedestrian phase
          // always runs the full max_green.
          ped_entered_d = ped_pending_q;
        end
      end

      S_CG: begin
        if (timer_zero || (!x && !ped_entered_q)) begin
          state_d = S_CY;
          timer_d = load_val(y2rdelay);
        end
      end

      S_CY: begin
        if (timer_zero) begin
          state_d = S_AR2;
          timer_d = load_val(r2gdelay);
        end
      end

      S_AR2: begin
        if (timer_zero) begin
          state_d = S_HG;
          timer_d = load_val(min_green);
        end
      end

      S_FLASH: begin
        timer_d       = '0;
        flash_phase_d = ~flash_phase_q;
        if (!flash) begin
          state_d       = S_AR2;
          timer_d       = load_val(r2gdelay);
          flash_phase_d = 1'b0;
        end
      end

      default: begin
        // Unused code: recover to highway green.
        state_d = S_HG;
        timer_d = '0;
      end
    endcase
  end

  // Pedestrian latch: set outside CG, cleared on the CG entry edge
  always_comb begin
    enter_cg      = (state_q == S_AR1) && (state_d == S_CG);
    ped_pending_d = ped_pending_q;
    if (enter_cg) begin
      ped_pending_d = 1'b0;
    end else if ((state_q != S_CG) && ped_req) begin
      ped_pending_d = 1'b1;
    end
  end

  // State register with asynchronous active-low clear
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= S_HG;
      timer_q       <= '0;
      ped_pending_q <= 1'b0;
      ped_entered_q <= 1'b0;
      flash_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
      ped_entered_q <= ped_entered_d;
      flash_phase_q <= flash_phase_d;
    end
  end

  // Moore output decode
  always_comb begin
    hwy      = L_RED;
    cntry    = L_RED;
    ped_walk = 1'b0;
    case (state_q)
      S_HG: begin
        hwy   = L_GRN;
        cntry = L_RED;
      end
      S_HY: begin
        hwy   = L_YEL;
        cntry = L_RED;
      end
      S_CG: begin
        hwy      = L_RED;
        cntry    = L_GRN;
        ped_walk = 1'b1;
      end
      S_CY: begin
        hwy   = L_RED;
        cntry = L_YEL;
      end
      S_FLASH: begin
        hwy   = flash_phase_q ? L_OFF : L_YEL;
        cntry = flash_phase_q ? L_OFF : L_RED;
      end
      default: begin
        hwy   = L_RED;
        cntry = L_RED;
      end
    endcase
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: doc/sig_control_ped.md
Name: sig_control_ped

Overview:
Parametrised successor to the highway/country-road signal controller, for the same intersection.
- Adds programmable highway minimum green, country maximum green, a latched pedestrian request with a walk output, and a night flash mode.
- All timing is in clock cycles and comes from input ports, so firmware/bench can retime it without resynthesis.
- Outputs are Moore-decoded from the state register.

Parameters:
DLY_W, 4, width of every delay input and of the internal down-counter.

Ports:
clock  in  1  system clock, rising edge
clear_n  in  1  reset, asynchronous, active-low
x  in  1  car waiting on country road (level)
ped_req  in  1  pedestrian request (pulse or level; latched)
flash  in  1  night flash mode request (level)
y2rdelay  in  DLY_W  yellow duration, cycles
r2gdelay  in  DLY_W  all-red clearance duration, cycles
min_green  in  DLY_W  minimum highway green, cycles
max_green  in  DLY_W  maximum country green, cycles
hwy  out  2  highway lamp: 0=RED 1=YELLOW 2=GREEN 3=OFF
cntry  out  2  country lamp, same encoding
ped_walk  out  1  walk indication for crossing the highway
state  out  3  current state code (debug/verification)

Behaviour:
- Reset and clock: one clock, `clock`; `clear_n` low asynchronously forces the reset values below.
  - state=HG(0), timer=0, ped_pending=0, flash_phase=0.
  - hence hwy=GREEN, cntry=RED, ped_walk=0.
  - Timer=0 means the first departure from HG is not held by min_green.
- Delay loading:
  - Each timed state loads timer = D-1 on the entering clock edge; D is sampled at that edge.
  - The state therefore lasts exactly D cycles. D=0 is treated as 1.
  - Timer counts down once per cycle and saturates at 0.
- States, with (hwy,cntry) outputs:
  - HG(0) (GREEN,RED), duration min_green: exit to HY when timer==0 and (x or ped_pending); otherwise hold indefinitely.
  - HY(1) (YELLOW,RED), duration y2rdelay: then AR1.
  - AR1(2) (RED,RED), duration r2gdelay: then CG.
  - CG(3) (RED,GREEN), duration max_green:
    - Exit to CY when timer==0, or when x==0 and CG was not entered with ped_pending set.
    - A pedestrian-entered CG always lasts the full max_green.
    - ped_walk=1 throughout CG only.
  - CY(4) (RED,YELLOW), duration y2rdelay: then AR2.
  - AR2(5) (RED,RED), duration r2gdelay: then HG.
  - FLASH(6) (YELLOW/OFF, RED/OFF):
    - flash_phase toggles every cycle, starting at 0 on entry; phase 0 = YELLOW,RED; phase 1 = OFF,OFF.
- Pedestrian latch:
  - ped_pending is set on any edge with ped_req=1 in states other than CG.
  - It is cleared on the edge entering CG.
  - ped_req during CG is ignored.
  - A "ped-entered" flag captures ped_pending at CG entry.
- Flash mode:
  - flash is honoured only from HG. flash=1 in HG moves to FLASH next edge regardless of timer, with priority over x/ped.
  - In other states flash waits until HG is reached.
  - flash=0 in FLASH moves to AR2, loading r2gdelay, then HG.
  - ped_pending is retained through FLASH.
- Simultaneous events:
  - x and ped both pending: a single country phase serves both, with ped rules (full max_green).
  - Delay inputs changing mid-state have no effect until the next entry.
- Reset mid-operation: async return to HG with the values above from any state, including FLASH.

Test Plan:
- Reset with x=0, ped_req=0, flash=0, clear_n held low 4 cycles, then high 20 cycles -> hwy=2, cntry=0, state=0 every cycle, ped_walk=0.
- y2r=3, r2g=2, min=4, max=6; x=1 held from reset release:
  - HG exits at first edge with x=1 (timer=0 after reset).
  - HY 3 cycles, AR1 2, CG 6 (max-green cut), CY 3, AR2 2.
  - HG holds exactly 4 cycles, then HY again.
- Same delays; x=1 until CG has run 2 cycles, then x=0 -> CG ends after cycle 3 (exit edge sees x==0); CY 3, AR2 2, then HG stays (x=0).
- x=0; one-cycle ped_req pulse in HG after min_green expired:
  - HY 3, AR1 2, CG full 6 cycles with ped_walk=1 exactly those 6 cycles.
  - ped_pending cleared; a ped_req pulse during CG produces no second cycle.
- flash=1 during CG -> sequence completes CY, AR2, HG.
  - Next edge enters FLASH; hwy alternates 1,3 and cntry 0,3 each cycle.
  - flash=0 -> AR2 for 2 cycles (RED,RED), then HG.
- y2rdelay=0, r2gdelay=0, x=1 -> HY and AR1 each last 1 cycle.
  - clear_n pulsed low mid-CG -> outputs immediately hwy=2, cntry=0, ped_walk=0, state=0 without waiting for a clock edge.
